// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STAGES_DEF = 6;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  // Stage indices along the in-order pipeline
  localparam int unsigned STG_PC      = 0;
  localparam int unsigned STG_IF_ID   = 1;
  localparam int unsigned STG_ID_EXE  = 2;
  localparam int unsigned STG_EXE_MEM = 3;
  localparam int unsigned STG_MEM_WB  = 4;
  localparam int unsigned STG_WB      = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_wdt.sv
// Stall watchdog: counts consecutive stalled RUN cycles and latches a sticky timeout.
module pipe_stall_wdt #(
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam int unsigned     CW    = $clog2(WDT_CYCLES);
  localparam logic [CW-1:0]   LIMIT = CW'(WDT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  // Saturating count of consecutive stalls; flag rises when the count reaches LIMIT
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!count_en_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (count_en_i && (cnt_d == LIMIT)) begin
      flag_d = 1'b1;
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_ctrl_multi.sv
// Pipeline controller: thermometer stalls, redirect flush/PC reload, halt/drain/resume,
// stall watchdog. Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_multi
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = NUM_STAGES_DEF,
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned REDIRECT_STAGE = STG_EXE_MEM,
  parameter int unsigned WDT_CYCLES     = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [NUM_STAGES-1:0] stallreq_in,
  input  logic                  trap_enable_in,
  input  logic [ADDR_WIDTH-1:0] trap_address_in,
  input  logic                  jump_enable_in,
  input  logic [ADDR_WIDTH-1:0] jump_address_in,
  input  logic                  halt_req_in,
  input  logic                  resume_in,
  output logic [NUM_STAGES-1:0] stall_out,
  output logic [NUM_STAGES-1:0] flush_out,
  output logic                  new_pc_valid_out,
  output logic [ADDR_WIDTH-1:0] new_pc_out,
  output logic                  halted_out,
  output logic                  wdt_timeout_out
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles_out,
  output logic [31:0]           perf_flush_count_out
`endif
);

  localparam int unsigned   DCW        = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(NUM_STAGES - 2);

  state_e                state_q, state_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0] resume_pc_q, resume_pc_d;
  logic                  resume_pend_q, resume_pend_d;

  logic [NUM_STAGES-1:0] eff_req, stall_vec, flush_vec;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] target;

  // Redirect arbitration; acceptance depends only on requests at or above the redirect
  // stage, so masking the lower requests below cannot feed back into it
  always_comb begin
    accept = (trap_enable_in || jump_enable_in) &&
             ((stallreq_in >> REDIRECT_STAGE) == '0);
    target = trap_enable_in ? trap_address_in : jump_address_in;
  end

  // Stall thermometer and redirect flush mask
  always_comb begin
    eff_req   = stallreq_in;
    flush_vec = '0;
    if (accept) begin
      for (int unsigned k = 0; k < REDIRECT_STAGE; k++) eff_req[k] = 1'b0;
      for (int unsigned k = 1; k < REDIRECT_STAGE; k++) flush_vec[k] = 1'b1;
    end
    for (int unsigned j = 0; j < NUM_STAGES; j++) stall_vec[j] = |(eff_req >> j);
    if (state_q != ST_RUN) stall_vec[0] = 1'b1;
  end

  // Halt/drain/resume sequencing and PC reload selection
  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    resume_pc_d      = resume_pc_q;
    resume_pend_d    = resume_pend_q;
    new_pc_valid_out = 1'b0;
    new_pc_out       = '0;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          new_pc_valid_out = 1'b1;
          new_pc_out       = target;
        end
        if (halt_req_in) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          resume_pc_d   = target;
          resume_pend_d = 1'b1;
        end
        if (eff_req == '0) begin
          if (drain_cnt_q == DRAIN_LAST) state_d = ST_HALTED;
          else drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume_in) begin
          state_d = ST_RUN;
          if (resume_pend_q) begin
            new_pc_valid_out = 1'b1;
            new_pc_out       = resume_pc_q;
          end
          resume_pend_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM and deferred-redirect registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      resume_pc_q   <= '0;
      resume_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      resume_pc_q   <= resume_pc_d;
      resume_pend_q <= resume_pend_d;
    end
  end

  assign stall_out  = stall_vec;
  assign flush_out  = flush_vec;
  assign halted_out = (state_q == ST_HALTED);

  pipe_stall_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk_i      (clk_in),
    .rst_ni     (reset_in),
    .count_en_i ((state_q == ST_RUN) && stall_vec[0]),
    .timeout_o  (wdt_timeout_out)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating stall-cycle and accepted-redirect counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((|stall_vec) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (accept && (perf_flush_q != '1))       perf_flush_d = perf_flush_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles_out = perf_stall_q;
  assign perf_flush_count_out  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_multi.sv
// Scoreboard bench for pipe_ctrl_multi: stimulus queues expected outputs, a negedge
// monitor pops and compares them, and separately matches every PC load against a queue.
module tb_pipe_ctrl_multi;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [5:0]  stallreq_in;
  logic        trap_enable_in;
  logic [31:0] trap_address_in;
  logic        jump_enable_in;
  logic [31:0] jump_address_in;
  logic        halt_req_in;
  logic        resume_in;
  logic [5:0]  stall_out;
  logic [5:0]  flush_out;
  logic        new_pc_valid_out;
  logic [31:0] new_pc_out;
  logic        halted_out;
  logic        wdt_timeout_out;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_out;
  logic [31:0] perf_flush_count_out;
`endif

  always #5 clk_in = ~clk_in;

  pipe_ctrl_multi #(
    .NUM_STAGES     (6),
    .ADDR_WIDTH     (32),
    .REDIRECT_STAGE (3),
    .WDT_CYCLES     (1024)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .stallreq_in      (stallreq_in),
    .trap_enable_in   (trap_enable_in),
    .trap_address_in  (trap_address_in),
    .jump_enable_in   (jump_enable_in),
    .jump_address_in  (jump_address_in),
    .halt_req_in      (halt_req_in),
    .resume_in        (resume_in),
    .stall_out        (stall_out),
    .flush_out        (flush_out),
    .new_pc_valid_out (new_pc_valid_out),
    .new_pc_out       (new_pc_out),
    .halted_out       (halted_out),
    .wdt_timeout_out  (wdt_timeout_out)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles_out (perf_stall_cycles_out),
    .perf_flush_count_out  (perf_flush_count_out)
`endif
  );

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        vld;
    logic [31:0] pc;
    logic        halted;
    logic        wdt;
    logic        chk_perf;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pc_q[$];
  exp_t        mon_e;
  logic [31:0] mon_pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [5:0] st, input logic [5:0] fl,
                            input logic v, input logic [31:0] pc, input logic h, input logic w);
    exp_t e;
    e.name = name; e.stall = st; e.flush = fl; e.vld = v; e.pc = pc;
    e.halted = h; e.wdt = w; e.chk_perf = 1'b0; e.perf_stall = '0; e.perf_flush = '0;
    exp_q.push_back(e);
    if (v) pc_q.push_back(pc);
  endtask

  task automatic expect_perf(input string name, input logic [31:0] ps, input logic [31:0] pf);
`ifdef PIPE_CTRL_PERF_EN
    exp_t e;
    e.name = name; e.stall = '0; e.flush = '0; e.vld = 1'b0; e.pc = '0;
    e.halted = 1'b0; e.wdt = 1'b0; e.chk_perf = 1'b1; e.perf_stall = ps; e.perf_flush = pf;
    exp_q.push_back(e);
`else
    if (name.len() < 0 && ps != pf) $display("unused");
`endif
  endtask

  task automatic reset_pulse();
    #1 reset_in = 1'b0;
    #1 reset_in = 1'b1;
  endtask

  // Monitor: checks queued expectations mid-cycle and every PC load the DUT presents
  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_perf) begin
`ifdef PIPE_CTRL_PERF_EN
        n_cmp++;
        if (perf_stall_cycles_out !== mon_e.perf_stall || perf_flush_count_out !== mon_e.perf_flush) begin
          n_bad++;
          $display("FAIL %s: got stall_cycles=%0d flushes=%0d / want stall_cycles=%0d flushes=%0d",
                   mon_e.name, perf_stall_cycles_out, perf_flush_count_out,
                   mon_e.perf_stall, mon_e.perf_flush);
        end
`endif
      end else begin
        n_cmp++;
        if ({stall_out, flush_out, new_pc_valid_out, new_pc_out, halted_out, wdt_timeout_out} !==
            {mon_e.stall, mon_e.flush, mon_e.vld, mon_e.pc, mon_e.halted, mon_e.wdt}) begin
          n_bad++;
          $display("FAIL %s: got stall=%b flush=%b pcv=%b pc=%h halt=%b wdt=%b / want stall=%b flush=%b pcv=%b pc=%h halt=%b wdt=%b",
                   mon_e.name, stall_out, flush_out, new_pc_valid_out, new_pc_out, halted_out,
                   wdt_timeout_out, mon_e.stall, mon_e.flush, mon_e.vld, mon_e.pc,
                   mon_e.halted, mon_e.wdt);
        end
      end
    end
    if (new_pc_valid_out === 1'b1) begin
      n_cmp++;
      if (pc_q.size() == 0) begin
        n_bad++;
        $display("FAIL pc_load: got unexpected load of %h / want no load", new_pc_out);
      end else begin
        mon_pc = pc_q.pop_front();
        if (new_pc_out !== mon_pc) begin
          n_bad++;
          $display("FAIL pc_load: got %h / want %h", new_pc_out, mon_pc);
        end
      end
    end
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    reset_in = 1'b0; stallreq_in = '0;
    trap_enable_in = 1'b0; trap_address_in = '0;
    jump_enable_in = 1'b0; jump_address_in = '0;
    halt_req_in = 1'b0; resume_in = 1'b0;
    step(); step();
    expect_out("reset", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    reset_in = 1'b1;
    step();
    expect_out("idle", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();

    // Stall thermometer and redirect arbitration
    stallreq_in = 6'b000100;
    expect_out("stall_thermo", 6'b000111, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    stallreq_in = 6'b100000;
    expect_out("stall_top", 6'b111111, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    stallreq_in = 6'b000000; jump_enable_in = 1'b1; jump_address_in = 32'h80;
    expect_out("jump", 6'b000000, 6'b000110, 1'b1, 32'h80, 1'b0, 1'b0); step();
    trap_enable_in = 1'b1; trap_address_in = 32'h100;
    expect_out("trap_wins", 6'b000000, 6'b000110, 1'b1, 32'h100, 1'b0, 1'b0); step();
    stallreq_in = 6'b010000;
    expect_out("redir_blocked", 6'b011111, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    stallreq_in = 6'b001000;
    expect_out("redir_block_rs", 6'b001111, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    stallreq_in = 6'b000110; trap_enable_in = 1'b0;
    expect_out("redir_masks_low", 6'b000000, 6'b000110, 1'b1, 32'h80, 1'b0, 1'b0); step();
    stallreq_in = 6'b000000; jump_enable_in = 1'b0;

    // Halt, drain with a deferred jump and a stalled cycle, resume
    halt_req_in = 1'b1;
    expect_out("halt_req", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    halt_req_in = 1'b0;
    expect_out("drain1", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    jump_enable_in = 1'b1; jump_address_in = 32'h40;
    expect_out("drain_jump", 6'b000001, 6'b000110, 1'b0, 32'h0, 1'b0, 1'b0); step();
    jump_enable_in = 1'b0; stallreq_in = 6'b000100;
    expect_out("drain_stalled", 6'b000111, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    stallreq_in = 6'b000000; resume_in = 1'b1;
    expect_out("drain_resume_ign", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    resume_in = 1'b0;
    expect_out("drain5", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    expect_out("drain6", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    expect_out("halted", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0); step();
    halt_req_in = 1'b1;
    expect_out("halted_hold", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0); step();
    halt_req_in = 1'b0; resume_in = 1'b1;
    expect_out("resume_load", 6'b000001, 6'b000000, 1'b1, 32'h40, 1'b1, 1'b0); step();
    resume_in = 1'b0;
    expect_out("run_after_resume", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();

    // Reset mid-drain discards the pending redirect
    halt_req_in = 1'b1;
    expect_out("halt_req2", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    halt_req_in = 1'b0; jump_enable_in = 1'b1; jump_address_in = 32'h44;
    expect_out("drain2_jump", 6'b000001, 6'b000110, 1'b0, 32'h0, 1'b0, 1'b0); step();
    jump_enable_in = 1'b0;
    reset_pulse();
    step();
    expect_out("reset_mid_drain", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    halt_req_in = 1'b1;
    expect_out("halt_req3", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    halt_req_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out("drain3", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    end
    expect_out("halted3", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0); step();
    resume_in = 1'b1;
    expect_out("resume_no_pend", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0); step();
    resume_in = 1'b0;
    expect_out("run3", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();

    // Watchdog from a fresh reset
    reset_pulse();
    step();
    stallreq_in = 6'b000001;
    expect_out("wdt_c1", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    repeat (1021) step();
    expect_out("wdt_c1023", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    expect_out("wdt_c1024", 6'b000001, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1); step();
    stallreq_in = 6'b000000;
    expect_out("wdt_sticky", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_perf("perf_1024", 32'd1024, 32'd0); step();
    repeat (3) step();
    expect_out("wdt_still", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1); step();
    reset_pulse();
    step();
    expect_out("wdt_reset", 6'b000000, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0); step();
    step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL exp_drain: got %0d unchecked expectations / want 0", exp_q.size());
    end
    n_cmp++;
    if (pc_q.size() != 0) begin
      n_bad++;
      $display("FAIL pc_drain: got %0d missing PC loads / want 0", pc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
